// File: rtl/svd_pkg.sv
// Shared constants, FSM state type and length clamp for the SVD mux select sequencer.
package svd_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;
    localparam int LEN_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // A length of 0, or anything beyond the lane count, means a full word.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if ((len == '0) || (len > LEN_W'(LANES))) begin
            return LEN_W'(LANES);
        end
        return len;
    endfunction

endpackage

// File: rtl/mux8_1.sv
// Plain 8:1 single-bit multiplexer.
module mux8_1 (
    input  logic       a0,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       a4,
    input  logic       a5,
    input  logic       a6,
    input  logic       a7,
    input  logic [2:0] sel,
    output logic       res
);

    always_comb begin
        res = a0;
        case (sel)
            3'd0: res = a0;
            3'd1: res = a1;
            3'd2: res = a2;
            3'd3: res = a3;
            3'd4: res = a4;
            3'd5: res = a5;
            3'd6: res = a6;
            3'd7: res = a7;
            default: res = a0;
        endcase
    end

endmodule

// File: rtl/mux8_sel_sequencer.sv
// Registers an 8-bit flag word and serialises it lane by lane through mux8_1.
// Handshakes: a beat transfers on a cycle where valid and ready are both high; valid never drops and data never changes while waiting for ready.
module mux8_sel_sequencer
    import svd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    output logic [LANES-1:0] out_word,
    output logic [SEL_W-1:0] sel,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output state_t           dbg_state
);

    state_t           state_q, state_d;
    logic [LANES-1:0] word_q, word_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             in_fire;

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (LEN_W'(sel_q) == (len_q - LEN_W'(1)));
    // Combinational from out_ready so a new word can be taken on the final beat.
    assign in_ready  = rst_n && ((state_q == IDLE) || (out_last && out_ready));
    assign in_fire   = in_valid && in_ready;

    assign out_word  = word_q;
    assign sel       = sel_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
        len_d   = len_q;
        if (state_q == IDLE) begin
            if (in_fire) begin
                word_d  = in_data;
                len_d   = clamp_len(in_len);
                sel_d   = '0;
                state_d = SEND;
            end
        end else if (out_ready) begin
            if (!out_last) begin
                sel_d = sel_q + SEL_W'(1);
            end else if (in_fire) begin
                word_d = in_data;
                len_d  = clamp_len(in_len);
                sel_d  = '0;
            end else begin
                sel_d   = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            sel_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
        end
    end

    mux8_1 u_mux (
        .a0  (word_q[0]),
        .a1  (word_q[1]),
        .a2  (word_q[2]),
        .a3  (word_q[3]),
        .a4  (word_q[4]),
        .a5  (word_q[5]),
        .a6  (word_q[6]),
        .a7  (word_q[7]),
        .sel (sel_q),
        .res (out_bit)
    );

endmodule

// File: doc/mux8_sel_sequencer.md
Name: mux8_sel_sequencer

Overview:
- Upstream control stage for mux8_1 in the SVD datapath.
- Accepts an 8-bit flag word (e.g. per-lane rotation/convergence flags) on a valid/ready handshake and registers it.
- Drives the registered word onto the mux inputs a0..a7 and steps sel from 0 to len-1, one lane per accepted beat.
- Presents each selected bit downstream as a valid/ready serial stream with a last marker.

Parameters:
- LANES, 8, number of mux inputs; fixed at 8 to match mux8_1.
- SEL_W, 3, select width; equals log2(LANES).
- LEN_W, 4, width of the per-word length field.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  8  flag word; bit i goes to mux input ai.
- in_len  input  LEN_W  number of lanes to emit (1..8); 0 means 8; values above 8 are clamped to 8.
- out_word  output  8  registered word, wired to a0..a7 of mux8_1.
- sel  output  SEL_W  registered lane select, wired to mux8_1 sel.
- out_bit  output  1  selected bit (res of internal mux8_1 instance).
- out_valid  output  1  out_bit/sel valid.
- out_ready  input  1  downstream accepts the current beat.
- out_last  output  1  current beat is the final lane of the word.
- busy  output  1  high while in SEND.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; state=IDLE.
  - out_word=0, sel=0, out_valid=0, out_last=0, busy=0, len register=0.
  - in_ready=0 while rst_n is low, 1 from the first cycle after release.
- FSM states: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: capture in_data into out_word, capture the effective length (0 or >8 becomes 8), set sel=0, go to SEND.
- SEND:
  - out_valid=1, busy=1.
  - out_last=1 exactly when sel==len-1.
  - While out_valid&!out_ready: sel, out_word and out_last hold stable (no drop, no advance).
  - On out_valid&out_ready&!out_last: sel increments by 1.
  - On out_valid&out_ready&out_last: the word is complete.
- End of word:
  - in_ready = IDLE | (SEND & out_last & out_ready). This is a combinational path from out_ready by design, to allow back-to-back words.
  - If a new word is accepted on the final beat: capture it, set sel=0, stay in SEND. The next beat is that word's lane 0 with no bubble.
  - Otherwise: go to IDLE, out_valid=0 next cycle, out_word retained, sel reset to 0.
- Timing:
  - Latency: first beat is valid the cycle after acceptance.
  - Throughput: 1 bit/cycle; a word of length L occupies exactly L beats with out_ready held high.
- Width rules:
  - sel never exceeds len-1, so it never wraps within a word.
  - A length-8 word ends at sel=7; the next word restarts at 0.
- Boundaries:
  - len=1: a single beat with out_last=1 on sel=0.
  - in_valid in SEND, other than on the final accepted beat: ignored, in_ready=0.
  - rst_n asserted mid-word: immediate abort; all outputs return to reset values; the partial word is discarded.
  - out_ready is don't-care in IDLE.

Decomposition:
- Shared package (svd_pkg):
  - LANES=8, SEL_W=3, LEN_W=4.
  - Enumerated state type {IDLE, SEND}.
  - Helper function that clamps the length (0 or >8 becomes 8).
- One sub-module: mux8_1, instantiated with a0..a7=out_word[0..7], sel=sel, res=out_bit.
- Everything else is flat in this block.

Test Plan:
- Reset, then in_data=8'b1011_0010, in_len=8, out_ready=1 → beats sel 0..7 give out_bit 0,1,0,0,1,1,0,1; out_last only on sel=7; 8 beats total; in_ready=1 on the last beat.
- in_data=8'hFF, in_len=3 → 3 beats, out_bit=1; out_last at sel=2; IDLE next cycle with out_valid=0; in_len=0 later gives 8 beats; in_len=12 gives 8 beats.
- Backpressure: in_data=8'h5A, len=8, out_ready toggled 1,0,0,1,... → sel/out_bit/out_last stable during the stalled cycles; the downstream-collected sequence equals 0,1,0,1,1,0,1,0.
- Back-to-back: word A=8'h0F len=4, then B=8'hF0 len=4 with in_valid held high → A's last beat (sel=3) accepts B; the next cycle is B sel=0 with out_bit=0; 8 consecutive valid beats with no bubble.
- Reset mid-word: assert rst_n=0 at sel=4 of an 8-lane word → outputs go to reset values immediately (sel=0, out_valid=0, out_word=0); after release a new word starts at sel=0.
- len=1 with in_data=8'h01 → one beat, out_bit=1, out_last=1, sel=0; busy is high for exactly 1 cycle.
